// File: rtl/write_channels_resp_if.sv
// Write-channel bundle for write_channels_resp.
//   aw*  : write-address channel (awvalid/awready, awid, awaddr, awatop)
//   w*   : write-data channel (wvalid/wready, wdata, wstrb, wlast)
//   b*   : write response (bvalid/bready, bid, bcomp: 1 = success)
//   mem_*: 128-bit line write to memory (mem_wmask bit 1 = byte NOT written)
// Modport slave is the write_channels_resp side; master is the requester
// plus memory side (testbench).
interface write_channels_resp_if;
   logic         awvalid;
   logic         awready;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [5:0]   awatop;

   logic         wvalid;
   logic         wready;
   logic [31:0]  wdata;
   logic [31:0]  wstrb;
   logic         wlast;

   logic         bvalid;
   logic         bready;
   logic [3:0]   bid;
   logic         bcomp;

   logic         mem_wreq;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [15:0]  mem_wmask;
   logic         mem_wack;

   modport slave (
      input  awvalid, awid, awaddr, awatop,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bcomp,
      input  bready,
      output mem_wreq, mem_addr, mem_wdata, mem_wmask,
      input  mem_wack
   );

   modport master (
      output awvalid, awid, awaddr, awatop,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bcomp,
      output bready,
      input  mem_wreq, mem_addr, mem_wdata, mem_wmask,
      output mem_wack
   );
endinterface

// File: rtl/write_channels_resp.sv
// Collects one write burst (AW + W beats) into a 128-bit line, issues it as a
// single masked line write to memory, then returns a B response.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - write_channels_resp_if.slave (AW, W, B channels and memory write)
// Parameter WACK_TIMEOUT: max MEMWR cycles waiting for mem_wack before the
// write is abandoned and an error response is returned.
module write_channels_resp #(
   parameter int unsigned WACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   write_channels_resp_if.slave  bus
);

   localparam int unsigned CW = (WACK_TIMEOUT > 1) ? $clog2(WACK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, DATA, MEMWR, RESP} state_t;

   state_t         state, state_next;
   logic [3:0]     id_q;
   logic [27:0]    addr_q;
   logic [1:0]     idx;
   logic [2:0]     beat_cnt;   // saturates at 4; bit 2 marks a full line
   logic [127:0]   line;
   logic [15:0]    mask;
   logic           err;
   logic           err_set;
   logic [CW-1:0]  wait_cnt;
   logic           w_hs;
   logic           tmo;
   logic           unused;

   assign w_hs = bus.wvalid & (state == DATA);
   assign tmo  = (32'(wait_cnt) + 32'd1) >= WACK_TIMEOUT;

   // Next state; err_set flags an error raised in this cycle so that a
   // wlast beat which is itself the overflow beat skips MEMWR.
   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      case (state)
         IDLE:    if (bus.awvalid) state_next = DATA;
         DATA: begin
            if (w_hs) begin
               err_set = beat_cnt[2];
               if (bus.wlast) state_next = (err | err_set) ? RESP : MEMWR;
            end
         end
         MEMWR: begin
            if (bus.mem_wack) begin
               state_next = RESP;
            end else if (tmo) begin
               state_next = RESP;
               err_set    = 1'b1;
            end
         end
         RESP:    if (bus.bready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         idx      <= '0;
         beat_cnt <= '0;
         line     <= '0;
         mask     <= '1;
         err      <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.awvalid) begin
            id_q     <= bus.awid;
            addr_q   <= bus.awaddr[31:4];
            idx      <= bus.awaddr[3:2];
            beat_cnt <= '0;
            line     <= '0;
            mask     <= '1;
            err      <= |bus.awatop;
            wait_cnt <= '0;
         end
         // Beats past the fourth are accepted but never touch the line.
         if (w_hs && !beat_cnt[2]) begin
            line[{idx, 5'd0} +: 32] <= bus.wdata;
            mask[{idx, 2'd0} +: 4]  <= mask[{idx, 2'd0} +: 4] & ~bus.wstrb[3:0];
            idx                     <= idx + 2'd1;
            beat_cnt                <= beat_cnt + 3'd1;
         end
         if (state == MEMWR) wait_cnt <= wait_cnt + 1'b1;
         if (err_set) err <= 1'b1;
         if (state == RESP && bus.bready) err <= 1'b0;
      end
   end

   assign bus.awready   = (state == IDLE);
   assign bus.wready    = (state == DATA);
   assign bus.mem_wreq  = (state == MEMWR);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = line;
   assign bus.mem_wmask = mask;
   assign bus.bvalid    = (state == RESP);
   assign bus.bid       = id_q;
   // Gated by RESP so bcomp reads 0 while idle and during reset.
   assign bus.bcomp     = (state == RESP) & ~err;

   assign unused = ^{bus.wstrb[31:4], bus.awaddr[1:0]};

endmodule

// File: tb/tb_write_channels_resp.sv
module tb_write_channels_resp;

   logic clk = 1'b0;
   logic rst = 1'b1;

   write_channels_resp_if bus();

   write_channels_resp #(.WACK_TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [27:0]  addr;
      logic [127:0] data;
      logic [15:0]  mask;
   } mem_t;

   typedef struct {
      logic [3:0] id;
      logic       comp;
   } resp_t;

   mem_t  mem_q[$];
   resp_t resp_q[$];

   int passed = 0;
   int total  = 0;
   int wreq_cycles = 0;

   logic [31:0] bd[8];
   logic [31:0] bs[8];

   always @(negedge clk) if (bus.mem_wreq === 1'b1) wreq_cycles++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awready"},   bus.awready,   1);
      check({tag, "_wready"},    bus.wready,    0);
      check({tag, "_bvalid"},    bus.bvalid,    0);
      check({tag, "_bid"},       bus.bid,       0);
      check({tag, "_bcomp"},     bus.bcomp,     0);
      check({tag, "_mem_wreq"},  bus.mem_wreq,  0);
      check({tag, "_mem_addr"},  bus.mem_addr,  0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      check({tag, "_mem_wmask"}, bus.mem_wmask, 16'hffff);
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] atop);
      int n = 0;
      bus.awvalid = 1'b1;
      bus.awid    = id;
      bus.awaddr  = addr;
      bus.awatop  = atop;
      while (bus.awready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("awready", bus.awready, 1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] data, input logic [31:0] strb, input logic last);
      int n = 0;
      bus.wvalid = 1'b1;
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wlast  = last;
      while (bus.wready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("wready", bus.wready, 1);
      @(posedge clk); #1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
   endtask

   // wack_dly < 0: memory never acknowledges. bready_dly < 0: bready high early.
   task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] atop,
                          input int nb, input int wack_dly, input int bready_dly);
      logic [127:0] line = '0;
      logic [15:0]  mask = '1;
      logic [1:0]   idx  = addr[3:2];
      logic         err  = (atop != 6'd0);
      logic         tmo;
      int           wreq_start;
      int           cnt;
      mem_t         m;
      resp_t        r;

      for (int k = 0; k < nb; k++) begin
         if (k < 4) begin
            line[{idx, 5'd0} +: 32] = bd[k];
            for (int b = 0; b < 4; b++) if (bs[k][b]) mask[{idx, 2'd0} + b] = 1'b0;
            idx = idx + 2'd1;
         end else begin
            err = 1'b1;
         end
      end
      tmo = !err && (wack_dly < 0);
      if (!err) mem_q.push_back('{addr: addr[31:4], data: line, mask: mask});
      resp_q.push_back('{id: id, comp: !(err || tmo)});

      wreq_start = wreq_cycles;
      if (bready_dly < 0) bus.bready = 1'b1;
      do_aw(id, addr, atop);
      check("aw_stall_in_data", bus.awready, 0);
      for (int k = 0; k < nb; k++) do_w(bd[k], bs[k], k == nb - 1);

      if (!err) begin
         check("mreq_latency", bus.mem_wreq, 1);
         if (mem_q.size() == 0) begin
            total++;
            $error("FAIL mem_q_empty: observed 0 entries expected 1");
         end else begin
            m = mem_q.pop_front();
            check("mem_addr",  bus.mem_addr,  m.addr);
            check("mem_wdata", bus.mem_wdata, m.data);
            check("mem_wmask", bus.mem_wmask, m.mask);
         end
         if (wack_dly >= 0) begin
            for (int i = 0; i < wack_dly; i++) begin
               @(posedge clk); #1;
               check("mreq_hold", bus.mem_wreq, 1);
               check("mem_wdata_hold", bus.mem_wdata, m.data);
            end
            bus.mem_wack = 1'b1;
            @(posedge clk); #1;
            bus.mem_wack = 1'b0;
         end else begin
            cnt = 0;
            while (bus.mem_wreq === 1'b1 && cnt < 400) begin
               cnt++;
               @(posedge clk); #1;
            end
            check("timeout_cycles", cnt, 255);
         end
      end else begin
         check("no_mreq_err", bus.mem_wreq, 0);
      end

      r = resp_q.pop_front();
      check("bvalid", bus.bvalid, 1);
      check("bid", bus.bid, r.id);
      check("bcomp", bus.bcomp, r.comp);
      if (bready_dly >= 0) begin
         for (int i = 0; i < bready_dly; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", bus.bvalid, 1);
            check("bid_hold", bus.bid, r.id);
            check("bcomp_hold", bus.bcomp, r.comp);
         end
         bus.bready = 1'b1;
      end
      @(posedge clk); #1;
      bus.bready = 1'b0;
      check("bvalid_done", bus.bvalid, 0);
      check("awready_after_b", bus.awready, 1);
      check("wreq_cycles", wreq_cycles - wreq_start,
            err ? 0 : (tmo ? 255 : wack_dly + 1));
   endtask

   initial begin
      bus.awvalid  = 1'b0;
      bus.awid     = '0;
      bus.awaddr   = '0;
      bus.awatop   = '0;
      bus.wvalid   = 1'b0;
      bus.wdata    = '0;
      bus.wstrb    = '0;
      bus.wlast    = 1'b0;
      bus.bready   = 1'b0;
      bus.mem_wack = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      rst = 1'b0;
      @(posedge clk); #1;

      // Stray wvalid / mem_wack while idle are ignored.
      bus.wvalid   = 1'b1;
      bus.mem_wack = 1'b1;
      check("idle_wready", bus.wready, 0);
      @(posedge clk); #1;
      check("idle_stays", bus.awready, 1);
      check("idle_no_mreq", bus.mem_wreq, 0);
      check("idle_no_b", bus.bvalid, 0);
      bus.wvalid   = 1'b0;
      bus.mem_wack = 1'b0;

      // Full line, strobes f,f,0,f, immediate ack.
      bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333; bd[3] = 32'h44444444;
      bs[0] = 32'hf; bs[1] = 32'hf; bs[2] = 32'h0; bs[3] = 32'hf;
      run_txn(4'd3, 32'h100, 6'h00, 4, 0, 0);

      // Single beat into slot 2, ack after 2 cycles, bready high early.
      bd[0] = 32'hAAAAAAAA; bs[0] = 32'hf;
      run_txn(4'd5, 32'h208, 6'h00, 1, 2, -1);

      // Atomic -> error, no memory write.
      bd[0] = 32'h01020304; bd[1] = 32'h05060708; bd[2] = 32'h090a0b0c; bd[3] = 32'h0d0e0f10;
      bs[0] = 32'hf; bs[1] = 32'hf; bs[2] = 32'hf; bs[3] = 32'hf;
      run_txn(4'd7, 32'h300, 6'h01, 4, 0, 0);

      // Six beats -> overflow error.
      for (int k = 0; k < 6; k++) begin
         bd[k] = 32'hC0DE0000 + k;
         bs[k] = 32'hf;
      end
      run_txn(4'd9, 32'h500, 6'h00, 6, 0, 0);

      // Five beats, wlast on the overflow beat itself.
      run_txn(4'd2, 32'h540, 6'h00, 5, 0, 1);

      // Index wraps 3,0,1,2 with one byte per beat.
      bd[0] = 32'hDEADBEEF; bd[1] = 32'hCAFEF00D; bd[2] = 32'h12345678; bd[3] = 32'h9ABCDEF0;
      bs[0] = 32'h1; bs[1] = 32'h2; bs[2] = 32'h4; bs[3] = 32'h8;
      run_txn(4'd4, 32'h30C, 6'h00, 4, 1, 0);

      // No ack -> timeout after 255 cycles; bready held off for 10 cycles.
      bs[0] = 32'hf; bs[1] = 32'hf; bs[2] = 32'hf; bs[3] = 32'hf;
      run_txn(4'hC, 32'hABC0, 6'h00, 4, -1, 10);

      // Reset in DATA after two beats.
      do_aw(4'h6, 32'h400, 6'h00);
      do_w(32'h55555555, 32'hf, 1'b0);
      do_w(32'h66666666, 32'hf, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_no_b", bus.bvalid, 0);
      check("post_rst_no_mreq", bus.mem_wreq, 0);

      bd[0] = 32'h77777777; bd[1] = 32'h88888888; bd[2] = 32'h99999999; bd[3] = 32'hAAAA5555;
      bs[0] = 32'hf; bs[1] = 32'h3; bs[2] = 32'hf; bs[3] = 32'hc;
      run_txn(4'hA, 32'h404, 6'h00, 4, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
